lfsr_seq: RTL

Parametrised LFSR sequencer that runs a programmable number of shift steps from a loaded seed, then reports the final register value. It extends the start/busy stepping block's behaviour in four ways: configurable width, Fibonacci or Galois feedback, a one-cycle completion pulse, and lock-up detection plus period detection. It sits behind the control logic that supplies the tap polynomial and seed, and its output feeds the pseudo-random consumers.

---
 rtl/lfsr_pkg.sv | 42 ++++
 rtl/lfsr_seq_if.sv | 33 +++
 rtl/lfsr_step.sv | 22 ++
 rtl/lfsr_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lfsr_pkg                                               |
// | Description : Shared types, mode constants and LFSR step function.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package lfsr_pkg;

  // Widest register the shared step function can handle.
  localparam int LFSR_MAX_W = 64;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // One LFSR shift. Operands are zero-extended to LFSR_MAX_W bits and the
  // result is masked back to `width` bits. When width equals LFSR_MAX_W the
  // shifted-out one wraps to zero, so the mask becomes all ones.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input logic                  mode,
    input int                    width = LFSR_MAX_W
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] nxt;
    mask = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
    if (mode == MODE_GAL) begin
      nxt = (state >> 1) ^ (state[0] ? taps : '0);
    end else begin
      nxt = {state[LFSR_MAX_W-2:0], ^(state & taps)};
    end
    return nxt & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lfsr_seq_if                                            |
// | Description : Control/result bundle between sequencer and its host.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface lfsr_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] taps;
  logic [CNT_W-1:0] steps;
  logic             mode;
  logic [WIDTH-1:0] prod;
  logic             busy;
  logic             done;
  logic             lock_err;
  logic [CNT_W-1:0] period;
  logic             period_valid;

  modport master (
    output start, seed, taps, steps, mode,
    input  prod, busy, done, lock_err, period, period_valid
  );

  modport slave (
    input  start, seed, taps, steps, mode,
    output prod, busy, done, lock_err, period, period_valid
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lfsr_step                                              |
// | Description : Combinational next-value for Fibonacci/Galois LFSR.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] i_state,
  input  wire logic [WIDTH-1:0] i_taps,
  input  wire logic             i_mode,
  output logic      [WIDTH-1:0] o_next
);

  assign o_next = WIDTH'(lfsr_next(LFSR_MAX_W'(i_state), LFSR_MAX_W'(i_taps),
                                   i_mode, WIDTH));

endmodule
`default_nettype wire

// File: rtl/lfsr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lfsr_seq                                               |
// | Description : Runs N LFSR steps from a seed, flags lock-up & period. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lfsr_seq
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input wire logic  clk,
  input wire logic  rst,
  lfsr_seq_if.slave bus
);

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_prod,   w_prod_nxt;
  logic [WIDTH-1:0] r_seed,   w_seed_nxt;
  logic [WIDTH-1:0] r_taps,   w_taps_nxt;
  logic             r_mode,   w_mode_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [CNT_W-1:0] r_k,      w_k_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_pvalid, w_pvalid_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_lock,   w_lock_nxt;
  logic [WIDTH-1:0] w_step;

  lfsr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_state (r_prod),
    .i_taps  (r_taps),
    .i_mode  (r_mode),
    .o_next  (w_step)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_prod_nxt   = r_prod;
    w_seed_nxt   = r_seed;
    w_taps_nxt   = r_taps;
    w_mode_nxt   = r_mode;
    w_cnt_nxt    = r_cnt;
    w_k_nxt      = r_k;
    w_period_nxt = r_period;
    w_pvalid_nxt = r_pvalid;
    w_lock_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_seed_nxt   = bus.seed;
          w_taps_nxt   = bus.taps;
          w_mode_nxt   = bus.mode;
          w_cnt_nxt    = bus.steps;
          w_prod_nxt   = bus.seed;
          w_k_nxt      = '0;
          w_period_nxt = '0;
          w_pvalid_nxt = 1'b0;
          // An all-zero seed would never leave zero, so refuse the run.
          if (bus.seed == '0) begin
            w_lock_nxt = 1'b1;
          end else if (bus.steps == '0) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        w_prod_nxt = w_step;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        w_k_nxt    = r_k + CNT_W'(1);
        if ((w_step == r_seed) && !r_pvalid) begin
          w_period_nxt = r_k + CNT_W'(1);
          w_pvalid_nxt = 1'b1;
        end
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_FIN;
        end
      end

      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_prod   <= '0;
      r_seed   <= '0;
      r_taps   <= '0;
      r_mode   <= MODE_FIB;
      r_cnt    <= '0;
      r_k      <= '0;
      r_period <= '0;
      r_pvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prod   <= w_prod_nxt;
      r_seed   <= w_seed_nxt;
      r_taps   <= w_taps_nxt;
      r_mode   <= w_mode_nxt;
      r_cnt    <= w_cnt_nxt;
      r_k      <= w_k_nxt;
      r_period <= w_period_nxt;
      r_pvalid <= w_pvalid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_lock   <= w_lock_nxt;
    end
  end

  assign bus.prod         = r_prod;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.lock_err     = r_lock;
  assign bus.period       = r_period;
  assign bus.period_valid = r_pvalid;

endmodule
`default_nettype wire
